// File: rtl/dm_pkg.sv
// Shared types and default sizing for the data-memory responder and its latency counter.
// Holds no logic; latency and flow-control behaviour live in the modules that import it.
package dm_pkg;

   localparam int DM_ADDR_W          = 7;
   localparam int DM_DATA_W          = 16;
   localparam int DM_DEPTH           = 128;
   localparam int DM_LATENCY_DEFAULT = 98;
   localparam int DM_CNT_W           = 8;

   typedef enum logic [1:0] {
      DM_IDLE = 2'd0,
      DM_BUSY = 2'd1,
      DM_HOLD = 2'd2
   } dm_state_e;

   typedef enum logic {
      DM_OP_READ  = 1'b0,
      DM_OP_WRITE = 1'b1
   } dm_op_e;

endpackage

// File: rtl/dm_latency_counter.sv
// Loadable 8-bit down-counter with zero flag; pacing source for the responder's BUSY phase.
// Updates one cycle after load/enable; no backpressure, saturates at zero while enabled.
module dm_latency_counter
   import dm_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic [DM_CNT_W-1:0] load_val_i,
   input  logic                en_i,
   output logic                zero_o
);

   logic [DM_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DM_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dm_responder.sv
// Block-store data memory serving one full-block read or write per request after LATENCY cycles.
// busy_wait stalls the requester for LATENCY+1 cycles; a served request is held off until it changes.
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_W  = DM_ADDR_W,
   parameter int DATA_W  = DM_DATA_W,
   parameter int DEPTH   = DM_DEPTH,
   parameter int LATENCY = DM_LATENCY_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              busy_wait
);

   localparam logic [DM_CNT_W-1:0] LOAD_VAL = DM_CNT_W'(LATENCY - 1);

   dm_state_e         state_q, state_d;
   dm_op_e            op_q, op_d, req_op;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic req_vld, req_same;
   logic cnt_load, cnt_en, cnt_zero;
   logic commit_wr;

   // read=write=1 is not a request at all
   assign req_vld  = read ^ write;
   assign req_op   = write ? DM_OP_WRITE : DM_OP_READ;
   assign req_same = req_vld && (req_op == op_q) && (address == addr_q)
                     && (write_data == wdata_q);

   assign cnt_load  = (state_q == DM_IDLE) && req_vld;
   assign cnt_en    = (state_q == DM_BUSY);
   assign commit_wr = (state_q == DM_BUSY) && cnt_zero && (op_q == DM_OP_WRITE);

   dm_latency_counter u_latency (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (LOAD_VAL),
      .en_i       (cnt_en),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         DM_IDLE: begin
            if (req_vld) begin
               state_d = DM_BUSY;
               op_d    = req_op;
               addr_d  = address;
               wdata_d = write_data;
            end
         end
         DM_BUSY: begin
            if (cnt_zero) begin
               state_d = DM_HOLD;
               if (op_q == DM_OP_READ) begin
                  rdata_d = mem_q[addr_q];
               end
            end
         end
         DM_HOLD: begin
            // the requester keeps driving the served request until it sees busy_wait low
            if (!req_same) begin
               state_d = DM_IDLE;
            end
         end
         default: state_d = DM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= DM_IDLE;
         op_q    <= DM_OP_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit_wr) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign busy_wait = ((state_q == DM_IDLE) && req_vld) || (state_q == DM_BUSY);
   assign read_data = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized and directed checks of dm_responder at LATENCY=98 and LATENCY=1 sharing one stimulus.
// A request-level model (remaining service cycles, last served request, block array) predicts both.
module tb_dm_responder;

   localparam int AW   = 7;
   localparam int DW   = 16;
   localparam int LAT0 = 98;
   localparam int LAT1 = 1;

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          read       = 1'b0;
   logic          write      = 1'b0;
   logic [AW-1:0] address    = '0;
   logic [DW-1:0] write_data = '0;
   logic [DW-1:0] rd0, rd1;
   logic          bw0, bw1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_responder #(.LATENCY(LAT0)) dut0 (
      .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
      .write_data(write_data), .read_data(rd0), .busy_wait(bw0)
   );

   dm_responder #(.LATENCY(LAT1)) dut1 (
      .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
      .write_data(write_data), .read_data(rd1), .busy_wait(bw1)
   );

   int            lat    [2] = '{LAT0, LAT1};
   int            rem    [2];
   bit            served [2];
   bit            c_wr   [2];
   logic [AW-1:0] c_addr [2];
   logic [DW-1:0] c_data [2];
   logic [DW-1:0] m_mem  [2][128];
   logic [DW-1:0] m_rd   [2];
   bit            live = 1'b0;
   logic          s_bw   [2];
   logic [DW-1:0] s_rd   [2];

   // Advance the model across one rising edge using the inputs present before it.
   task automatic model_step();
      bit vld;
      vld = read ^ write;
      if (!rst) live = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            rem[k] = 0;
            served[k] = 1'b0;
            m_rd[k] = '0;
            for (int a = 0; a < 128; a++) m_mem[k][a] = '0;
         end else if (rem[k] > 0) begin
            rem[k] = rem[k] - 1;
            if (rem[k] == 0) begin
               if (c_wr[k]) m_mem[k][c_addr[k]] = c_data[k];
               else         m_rd[k] = m_mem[k][c_addr[k]];
               served[k] = 1'b1;
            end
         end else if (served[k]) begin
            if (!(vld && (write == c_wr[k]) && (address == c_addr[k]) && (write_data == c_data[k])))
               served[k] = 1'b0;
         end else if (vld) begin
            c_wr[k]   = write;
            c_addr[k] = address;
            c_data[k] = write_data;
            rem[k]    = lat[k];
         end
      end
   endtask

   task automatic compare_all();
      logic eb;
      s_bw[0] = bw0; s_bw[1] = bw1;
      s_rd[0] = rd0; s_rd[1] = rd1;
      if (live) begin
         for (int k = 0; k < 2; k++) begin
            eb = (rem[k] > 0) || (!served[k] && (read ^ write));
            checks++;
            if (s_bw[k] !== eb) begin
               errors++;
               $display("FAIL busy_wait L=%0d t=%0t got %b want %b", lat[k], $time, s_bw[k], eb);
            end
            checks++;
            if (s_rd[k] !== m_rd[k]) begin
               errors++;
               $display("FAIL read_data L=%0d t=%0t got %h want %h", lat[k], $time, s_rd[k], m_rd[k]);
            end
         end
      end
   endtask

   // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk);
      compare_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic drive(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      read = r; write = w; address = a; write_data = d;
   endtask

   // Present a request and run until dut0 drops busy_wait; optionally alter address/data mid-service.
   task automatic access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int chg_at, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                         output int n0, output int n1);
      bit seen, done;
      drive(!w, w, a, d);
      n0 = 0; n1 = 0; seen = 1'b0; done = 1'b0;
      for (int g = 0; g < 400 && !done; g++) begin
         tick();
         if (s_bw[0] === 1'b1) begin n0++; seen = 1'b1; end
         if (s_bw[1] === 1'b1) n1++;
         if (seen && s_bw[0] === 1'b0) done = 1'b1;
         if (chg_at != 0 && n0 == chg_at) begin address = a2; write_data = d2; end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL access timeout addr %h got busy_count %0d want completion", a, n0);
      end
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, address, write_data);
      tick();
   endtask

   initial begin
      int n0, n1, cnt0, cnt1;
      logic [AW-1:0] ra, prev_a;
      logic [DW-1:0] rdat;
      bit rw;

      drive(1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      lit("reset busy_wait", s_bw[0], 0);
      lit("reset read_data", s_rd[0], 0);

      access(1'b0, 7'h05, '0, 0, '0, '0, n0, n1);
      lit("read busy cycles L98", n0, 99);
      lit("read busy cycles L1", n1, 2);
      lit("unwritten read 05", s_rd[0], 16'h0000);
      idle_cycle();

      access(1'b1, 7'h0C, 16'h0107, 0, '0, '0, n0, n1);
      lit("write busy cycles L98", n0, 99);
      idle_cycle();
      access(1'b0, 7'h0C, '0, 0, '0, '0, n0, n1);
      lit("readback 0C L98", s_rd[0], 16'h0107);
      lit("readback 0C L1", s_rd[1], 16'h0107);

      // read stays high, only the address moves
      access(1'b0, 7'h1C, '0, 0, '0, '0, n0, n1);
      lit("back-to-back busy L98", n0, 99);
      lit("back-to-back busy L1", n1, 2);
      lit("unwritten read 1C", s_rd[0], 16'h0000);
      idle_cycle();

      access(1'b1, 7'h2A, 16'hA5A5, 0, '0, '0, n0, n1);
      cnt0 = 0; cnt1 = 0;
      repeat (20) begin
         tick();
         if (s_bw[0] !== 1'b0) cnt0++;
         if (s_bw[1] !== 1'b0) cnt1++;
      end
      lit("held write retrigger L98", cnt0, 0);
      lit("held write retrigger L1", cnt1, 0);
      idle_cycle();

      drive(1'b1, 1'b1, 7'h2A, 16'h0000);
      cnt0 = 0; cnt1 = 0;
      repeat (5) begin
         tick();
         if (s_bw[0] !== 1'b0) cnt0++;
         if (s_bw[1] !== 1'b0) cnt1++;
      end
      lit("illegal busy L98", cnt0, 0);
      lit("illegal busy L1", cnt1, 0);
      idle_cycle();
      access(1'b0, 7'h2A, '0, 0, '0, '0, n0, n1);
      lit("readback 2A after illegal", s_rd[0], 16'hA5A5);
      idle_cycle();

      access(1'b1, 7'h30, 16'h1234, 10, 7'h31, 16'hFFFF, n0, n1);
      idle_cycle();
      access(1'b0, 7'h30, '0, 0, '0, '0, n0, n1);
      lit("captured write 30", s_rd[0], 16'h1234);
      idle_cycle();
      access(1'b0, 7'h31, '0, 0, '0, '0, n0, n1);
      lit("changed addr 31 untouched", s_rd[0], 16'h0000);
      idle_cycle();

      drive(1'b0, 1'b1, 7'h10, 16'hBEEF);
      repeat (51) tick();
      lit("busy before mid reset", s_bw[0], 1);
      drive(1'b0, 1'b0, 7'h10, 16'hBEEF);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      lit("busy after mid reset", s_bw[0], 0);
      access(1'b0, 7'h10, '0, 0, '0, '0, n0, n1);
      lit("aborted write 10", s_rd[0], 16'h0000);
      idle_cycle();

      prev_a = 7'h40;
      repeat (40) begin
         case ($urandom_range(0, 9))
            0: begin
               drive(1'b1, 1'b1, 7'(40 + $urandom_range(0, 7)), 16'($urandom));
               repeat (3) tick();
               idle_cycle();
            end
            1: begin
               drive(1'b0, 1'b0, address, write_data);
               rst = 1'b0;
               tick();
               rst = 1'b1;
               tick();
            end
            default: begin
               rw   = 1'($urandom_range(0, 1));
               ra   = 7'(8'h40 + 8'($urandom_range(0, 7)));
               rdat = 16'($urandom);
               if (ra == prev_a) ra = ra ^ 7'h01;
               if ($urandom_range(0, 3) == 0)
                  access(rw, ra, rdat, $urandom_range(2, 90), 7'(8'h40 + 8'($urandom_range(0, 7))),
                         16'($urandom), n0, n1);
               else
                  access(rw, ra, rdat, 0, '0, '0, n0, n1);
               prev_a = address;
               repeat ($urandom_range(0, 3)) tick();
               if ($urandom_range(0, 1) == 1) begin
                  idle_cycle();
                  prev_a = 7'h7F;
               end
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
